sht40_rx_parser: RTL

SHT40_RX_PARSER -- requirements
Module: sht40_rx_parser

---
 rtl/sht40_pkg.sv | 30 +++
 rtl/sht40_crc8.sv | 19 +
 rtl/sht40_rx_parser.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sht40_pkg.sv
// ----------------------------------------------------------------------------
// sht40_pkg
// Shared definitions for the SHT40 receive parser and the SCL/SDA master:
// parser state encoding, CRC-8 constants, frame length and a one-byte
// CRC-8 step function (poly 0x31, MSB first, no reflection, no final XOR).
// ----------------------------------------------------------------------------
package sht40_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2
   } sht40_state_e;

   localparam logic [7:0] CRC_POLY    = 8'h31;
   localparam logic [7:0] CRC_INIT    = 8'hFF;
   localparam int         FRAME_BYTES = 6;

   // Folds one byte into a running CRC-8, MSB first.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                            input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/sht40_crc8.sv
// ----------------------------------------------------------------------------
// sht40_crc8
// Combinational CRC-8 step: crc_out is crc_in with one data byte folded in.
// Ports:
//   crc_in  [7:0]  running CRC before the byte
//   data    [7:0]  byte to fold in
//   crc_out [7:0]  running CRC after the byte
// ----------------------------------------------------------------------------
module sht40_crc8
   import sht40_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   assign crc_out = crc8_byte(crc_in, data);

endmodule

// File: rtl/sht40_rx_parser.sv
// ----------------------------------------------------------------------------
// sht40_rx_parser
// Collects the six bytes of an SHT40 read frame (temp MSB, temp LSB, temp CRC,
// RH MSB, RH LSB, RH CRC), checks the two CRCs and publishes the words.
//
// Optional feature: define SHT40_RX_CRC_CHECK_EN to compile in CRC checking.
// Without it the CRC bytes are counted and dropped, crc_err is 2'b00 and both
// words update on every completed frame.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles allowed between bytes before the frame aborts
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   frame_start     pulse: open (or restart) a frame
//   byte_valid      strobe: byte_data holds a received byte
//   byte_data [7:0] received byte
//   last_byte       high while byte index 5 is expected (upstream sends NACK)
//   busy            high in COLLECT and CHECK
//   temp_raw [15:0] last accepted temperature word
//   rh_raw   [15:0] last accepted humidity word
//   data_valid      one-cycle pulse when a frame completes
//   crc_err  [1:0]  [0] temp CRC bad, [1] RH CRC bad; valid with data_valid
//   timeout         one-cycle pulse when a frame aborts on inactivity
//   state_dbg       current FSM state
//
// Handshake: byte_valid/frame_start are single-cycle strobes with no ready;
// a byte is consumed on the clk edge where byte_valid is high in COLLECT and
// frame_start is low. frame_start always wins and drops a coincident byte.
// ----------------------------------------------------------------------------
module sht40_rx_parser
   import sht40_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         frame_start,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   output logic         last_byte,
   output logic         busy,
   output logic [15:0]  temp_raw,
   output logic [15:0]  rh_raw,
   output logic         data_valid,
   output logic [1:0]   crc_err,
   output logic         timeout,
   output sht40_state_e state_dbg
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   sht40_state_e state;
   logic [2:0]   idx;
   logic [15:0]  idle_cnt;
   logic [7:0]   temp_msb, temp_lsb, rh_msb, rh_lsb;

   assign state_dbg = state;

`ifdef SHT40_RX_CRC_CHECK_EN
   logic [7:0] crc_q;
   logic [7:0] crc_next;
   logic       temp_ok;
   logic       rh_ok;
   logic [1:0] crc_err_q;

   sht40_crc8 u_crc8 (
      .crc_in  (crc_q),
      .data    (byte_data),
      .crc_out (crc_next)
   );

   assign crc_err = crc_err_q;
`else
   assign crc_err = 2'b00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         idle_cnt   <= 16'd0;
         temp_msb   <= 8'h00;
         temp_lsb   <= 8'h00;
         rh_msb     <= 8'h00;
         rh_lsb     <= 8'h00;
         temp_raw   <= 16'h0000;
         rh_raw     <= 16'h0000;
         data_valid <= 1'b0;
         timeout    <= 1'b0;
         last_byte  <= 1'b0;
         busy       <= 1'b0;
`ifdef SHT40_RX_CRC_CHECK_EN
         crc_q      <= CRC_INIT;
         temp_ok    <= 1'b0;
         rh_ok      <= 1'b0;
         crc_err_q  <= 2'b00;
`endif
      end else begin
         data_valid <= 1'b0;
         timeout    <= 1'b0;
         if (frame_start) begin
            // Open or restart: anything collected so far is abandoned.
            state     <= ST_COLLECT;
            idx       <= 3'd0;
            idle_cnt  <= 16'd0;
            last_byte <= 1'b0;
            busy      <= 1'b1;
`ifdef SHT40_RX_CRC_CHECK_EN
            crc_q     <= CRC_INIT;
`endif
         end else begin
            case (state)
               ST_IDLE: begin
                  last_byte <= 1'b0;
                  busy      <= 1'b0;
               end

               ST_COLLECT: begin
                  if (byte_valid) begin
                     idle_cnt <= 16'd0;
                     case (idx)
                        3'd0:    temp_msb <= byte_data;
                        3'd1:    temp_lsb <= byte_data;
                        3'd3:    rh_msb   <= byte_data;
                        3'd4:    rh_lsb   <= byte_data;
                        default: ;
                     endcase
`ifdef SHT40_RX_CRC_CHECK_EN
                     // At a CRC byte the running CRC over the two data bytes
                     // must equal it; the RH word then starts a fresh CRC.
                     if (idx == 3'd2) begin
                        temp_ok <= (crc_q == byte_data);
                        crc_q   <= CRC_INIT;
                     end else if (idx == LAST_IDX) begin
                        rh_ok   <= (crc_q == byte_data);
                        crc_q   <= CRC_INIT;
                     end else begin
                        crc_q   <= crc_next;
                     end
`endif
                     if (idx == LAST_IDX) begin
                        state     <= ST_CHECK;
                        idx       <= 3'd0;
                        last_byte <= 1'b0;
                     end else begin
                        idx       <= idx + 3'd1;
                        last_byte <= (idx == LAST_IDX - 3'd1);
                     end
                  end else if (idle_cnt == TIMEOUT_CYCLES - 16'd1) begin
                     timeout   <= 1'b1;
                     state     <= ST_IDLE;
                     idx       <= 3'd0;
                     idle_cnt  <= 16'd0;
                     last_byte <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     idle_cnt  <= idle_cnt + 16'd1;
                  end
               end

               ST_CHECK: begin
                  data_valid <= 1'b1;
`ifdef SHT40_RX_CRC_CHECK_EN
                  // A word with a bad CRC keeps its previous value.
                  if (temp_ok) temp_raw <= {temp_msb, temp_lsb};
                  if (rh_ok)   rh_raw   <= {rh_msb, rh_lsb};
                  crc_err_q <= {~rh_ok, ~temp_ok};
`else
                  temp_raw  <= {temp_msb, temp_lsb};
                  rh_raw    <= {rh_msb, rh_lsb};
`endif
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
               end

               default: begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  last_byte <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
